// File: rtl/edge_detector_dual.sv
// Per-bit rising/falling edge detector: combinational Mealy pulses in the cycle the
// change is sampled, and registered Moore pulses one clock later.

module edge_detector_dual_lane (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pos_mealy,
  output logic neg_mealy,
  output logic pos_moore,
  output logic neg_moore
);

  typedef enum logic [1:0] {S_LOW, S_RISING, S_HIGH, S_FALLING} state_e;

  logic   prev_q, prev_d;
  state_e state_q, state_d;

  always_comb begin
    prev_d  = in;
    state_d = state_q;
    case (state_q)
      S_LOW:     state_d = in ? S_RISING : S_LOW;
      S_RISING:  state_d = in ? S_HIGH   : S_FALLING;
      S_HIGH:    state_d = in ? S_HIGH   : S_FALLING;
      S_FALLING: state_d = in ? S_RISING : S_LOW;
      default:   state_d = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      state_q <= S_LOW;
    end else begin
      prev_q  <= prev_d;
      state_q <= state_d;
    end
  end

  // rst gates the Mealy path so outputs drop the moment reset is applied.
  assign pos_mealy = rst & in & ~prev_q;
  assign neg_mealy = rst & ~in & prev_q;
  assign pos_moore = (state_q == S_RISING);
  assign neg_moore = (state_q == S_FALLING);

endmodule

module edge_detector_dual #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] positive_edge,
  output logic [WIDTH-1:0] negative_edge,
  output logic [WIDTH-1:0] positive_edge_moore,
  output logic [WIDTH-1:0] negative_edge_moore
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    edge_detector_dual_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .in        (in[i]),
      .pos_mealy (positive_edge[i]),
      .neg_mealy (negative_edge[i]),
      .pos_moore (positive_edge_moore[i]),
      .neg_moore (negative_edge_moore[i])
    );
  end

endmodule

// File: tb/tb_edge_detector_dual.sv
// Bench for edge_detector_dual: hand-computed vector table, then random stimulus
// checked against a sampled-level history model, plus pulse counting on random gaps.

module tb_edge_detector_dual;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] pe, ne, pem, nem;

  int compared   = 0;
  int mismatched = 0;

  // Level history: value sampled at the last posedge and the one before it.
  logic [W-1:0] m_prev  = '0;
  logic [W-1:0] m_prev2 = '0;

  edge_detector_dual #(.WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in                  (din),
    .positive_edge       (pe),
    .negative_edge       (ne),
    .positive_edge_moore (pem),
    .negative_edge_moore (nem)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         r;
    logic [W-1:0] v;
    logic [W-1:0] pos, neg, posm, negm;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    rst = r;
    din = v;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      m_prev  = '0;
      m_prev2 = '0;
    end else begin
      m_prev2 = m_prev;
      m_prev  = din;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] chg;
    chg = rst ? (din ^ m_prev) : '0;
    chk({tag, ".pos"},  pe,  chg & din);
    chk({tag, ".neg"},  ne,  chg & ~din);
    chk({tag, ".posm"}, pem, m_prev & ~m_prev2);
    chk({tag, ".negm"}, nem, ~m_prev & m_prev2);
  endtask

  vec_t tbl[11];
  int   cnt_pe, cnt_ne, cnt_pem, cnt_nem;
  logic lvl;

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0101, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b1, 4'b1010, 4'b1010, 4'b0101, 4'b0100, 4'b0010};
    tbl[6]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0101};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    // Two reset cycles before the first check.
    apply(1'b0, '0); advance();
    apply(1'b0, '0); advance();

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].v);
      chk($sformatf("vec%0d.pos", i),  pe,  tbl[i].pos);
      chk($sformatf("vec%0d.neg", i),  ne,  tbl[i].neg);
      chk($sformatf("vec%0d.posm", i), pem, tbl[i].posm);
      chk($sformatf("vec%0d.negm", i), nem, tbl[i].negm);
      advance();
    end

    // Fast toggle on all bits.
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, (i % 2) ? '1 : '0);
      check_model("toggle");
      advance();
    end

    // Random levels with occasional reset.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 31) != 0), W'($urandom));
      check_model("rand");
      advance();
    end

    // Ten toggles of every bit with random gaps; count pulses on bit 0.
    apply(1'b0, '0); advance();
    cnt_pe = 0; cnt_ne = 0; cnt_pem = 0; cnt_nem = 0;
    lvl = 1'b0;
    for (int t = 0; t < 10; t++) begin
      int gap;
      lvl = ~lvl;
      gap = $urandom_range(1, 128);
      for (int g = 0; g < gap; g++) begin
        apply(1'b1, {W{lvl}});
        check_model("gap");
        chk("excl", (pe & ne) | (pem & nem), '0);
        cnt_pe  += int'(pe[0]);
        cnt_ne  += int'(ne[0]);
        cnt_pem += int'(pem[0]);
        cnt_nem += int'(nem[0]);
        advance();
      end
    end
    // Let the last Moore pulse appear.
    apply(1'b1, {W{lvl}});
    cnt_pem += int'(pem[0]);
    cnt_nem += int'(nem[0]);
    advance();
    chk("cnt_pe",  W'(cnt_pe),  W'(5));
    chk("cnt_ne",  W'(cnt_ne),  W'(5));
    chk("cnt_pem", W'(cnt_pem), W'(5));
    chk("cnt_nem", W'(cnt_nem), W'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/edge_detector_dual.md
Name: edge_detector_dual

Overview:
- Per-bit rising/falling edge detector on a WIDTH-bit level input, producing two versions of each edge pulse side by side.
- Mealy outputs are combinational from the live input and the registered previous input. They are asserted in the same cycle the change is sampled.
- Moore outputs are decoded purely from a registered 4-state FSM per bit. They assert one clock later than the Mealy outputs and are glitch-free.
- Used for button/strobe-to-pulse conversion in front of sequencers and counters.

Parameters:
- WIDTH, 1, number of independent input bits; each bit has its own detector.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets).
- in  input  WIDTH  level input; synchronous to clk (no internal synchronizer).
- positive_edge  output  WIDTH  Mealy rising-edge pulse per bit.
- negative_edge  output  WIDTH  Mealy falling-edge pulse per bit.
- positive_edge_moore  output  WIDTH  Moore rising-edge pulse per bit.
- negative_edge_moore  output  WIDTH  Moore falling-edge pulse per bit.

Behaviour:
- Reset (rst==0 at posedge):
  - prev register <= 0.
  - Every Moore FSM <= S_LOW.
  - While rst==0, the Mealy outputs are forced to 0 combinationally. All four outputs read 0 the cycle after reset.
- Mealy path, per bit i:
  - prev[i] <= in[i] each posedge.
  - positive_edge[i] = rst & in[i] & ~prev[i].
  - negative_edge[i] = rst & ~in[i] & prev[i].
  - The pulse is high from the input change until the next posedge, so it is 1 cycle wide when in is stable across that edge.
- Moore FSM, per bit, 2-bit state, states S_LOW, S_RISING, S_HIGH, S_FALLING:
  - S_LOW: in=1 -> S_RISING; else stay.
  - S_RISING: in=1 -> S_HIGH; in=0 -> S_FALLING.
  - S_HIGH: in=0 -> S_FALLING; else stay.
  - S_FALLING: in=0 -> S_LOW; in=1 -> S_RISING.
  - positive_edge_moore = (state==S_RISING).
  - negative_edge_moore = (state==S_FALLING).
  - Outputs depend only on state, so the Moore pulse covers exactly the full clock cycle after the sampling edge. It lags the Mealy pulse by one posedge.
- Boundary conditions:
  - Input toggling every cycle: every cycle produces a pulse. Moore alternates RISING/FALLING; Mealy alternates pos/neg.
  - Positive and negative outputs of the same bit are never simultaneously 1.
  - in=1 at reset release: prev=0 and state=S_LOW, so a rising edge is reported. Mealy reports it immediately; Moore reports it the next cycle.
  - Reset asserted mid-pulse: all outputs are 0 starting the cycle reset is sampled (Mealy immediately, Moore after that posedge).
  - Bits are fully independent; no cross-bit interaction.
- Latency, counted from the first posedge sampling the new level:
  - Mealy: 0 cycles; active before that edge.
  - Moore: high for the cycle following that edge.

Test Plan:
- Reset: rst=0 for 2 cycles with in=0, then rst=1 -> all outputs 0, FSM S_LOW.
- Single rise: in 0->1 at a negedge, held 5 cycles -> positive_edge=1 for the half-cycle up to the next posedge; positive_edge_moore=1 for the following full cycle; no negative pulses.
- Single fall: from steady high, in 1->0, held 5 cycles -> negative_edge one pulse, then negative_edge_moore one cycle later; no positive pulses.
- Fast toggle: in toggles every cycle for 6 cycles -> 6 alternating Mealy pulses and 6 alternating Moore pulses, each Moore pulse one cycle after its Mealy pulse.
- Random delays: 10 toggles with random gaps of 1..128 cycles -> exactly 10 Mealy and 10 Moore pulses total. Counts per polarity match on both paths, and pos/neg are never both high.
- Reset with in=1: release rst while in=1 -> one positive_edge, then one positive_edge_moore. Assert rst=0 mid-high -> outputs 0; FSM returns to S_LOW.
